// File: rtl/bsg_and_pkg.sv
// Shared definitions for the bitwise AND datapath and its operand join.
package bsg_and_pkg;

    localparam int bsg_and_width_gp = 64;

    // Per-cycle activity of one side FIFO, encoded as {push, pop}.
    typedef enum logic [1:0] {
        op_idle = 2'b00,
        op_pop  = 2'b01,
        op_push = 2'b10,
        op_both = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/bsg_and_join_side_fifo.sv
// One operand side of the join: circular storage, pointers, occupancy count.
// Pop is commanded externally so both sides can leave in lockstep.
module bsg_and_join_side_fifo
    import bsg_and_pkg::*;
#(
    parameter int width_p = bsg_and_width_gp,
    parameter int els_p   = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_o,
    input  logic                       pop_i,
    output logic [width_p-1:0]         data_o,
    output logic                       empty_o,
    output logic [$clog2(els_p+1)-1:0] count_o
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] rptr_r;
    logic [ptr_w_lp-1:0] wptr_r;
    logic [ptr_w_lp-1:0] rptr_nxt_s;
    logic [ptr_w_lp-1:0] wptr_nxt_s;
    logic [cnt_w_lp-1:0] count_r;
    logic [cnt_w_lp-1:0] count_nxt_s;
    logic                push_s;
    logic                pop_s;
    fifo_op_e            op_s;

    // Pointers wrap explicitly so els_p need not be a power of two.
    function automatic logic [ptr_w_lp-1:0] wrap_inc(input logic [ptr_w_lp-1:0] ptr);
        if (ptr == ptr_w_lp'(els_p - 1)) begin
            return {ptr_w_lp{1'b0}};
        end else begin
            return ptr + ptr_w_lp'(1);
        end
    endfunction

    assign ready_o = (count_r != cnt_w_lp'(els_p));
    assign empty_o = (count_r == {cnt_w_lp{1'b0}});
    assign push_s  = v_i & ready_o;
    assign pop_s   = pop_i & ~empty_o;
    assign op_s    = fifo_op_e'({push_s, pop_s});
    assign data_o  = mem_r[rptr_r];
    assign count_o = count_r;

    // Next pointer/count from this cycle's push and pop.
    always_comb begin
        rptr_nxt_s  = rptr_r;
        wptr_nxt_s  = wptr_r;
        count_nxt_s = count_r;
        case (op_s)
            op_push: begin
                wptr_nxt_s  = wrap_inc(wptr_r);
                count_nxt_s = count_r + cnt_w_lp'(1);
            end
            op_pop: begin
                rptr_nxt_s  = wrap_inc(rptr_r);
                count_nxt_s = count_r - cnt_w_lp'(1);
            end
            op_both: begin
                wptr_nxt_s = wrap_inc(wptr_r);
                rptr_nxt_s = wrap_inc(rptr_r);
            end
            op_idle: begin
                count_nxt_s = count_r;
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // Control state register; reset discards all buffered entries.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_r  <= {ptr_w_lp{1'b0}};
            wptr_r  <= {ptr_w_lp{1'b0}};
            count_r <= {cnt_w_lp{1'b0}};
        end else begin
            rptr_r  <= rptr_nxt_s;
            wptr_r  <= wptr_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Operand storage is written only on a handshake and is never reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wptr_r] <= data_i;
        end
    end

endmodule

// File: rtl/bsg_and_operand_join.sv
// Joins independent A and B operand streams into in-order pairs for the AND
// stage; each side buffers up to els_p entries.
module bsg_and_operand_join
    import bsg_and_pkg::*;
#(
    parameter int width_p = bsg_and_width_gp,
    parameter int els_p   = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       a_v_i,
    input  logic [width_p-1:0]         a_data_i,
    output logic                       a_ready_o,
    input  logic                       b_v_i,
    input  logic [width_p-1:0]         b_data_i,
    output logic                       b_ready_o,
    output logic                       v_o,
    output logic [width_p-1:0]         a_o,
    output logic [width_p-1:0]         b_o,
    input  logic                       ready_i,
    output logic [$clog2(els_p+1)-1:0] a_count_o,
    output logic [$clog2(els_p+1)-1:0] b_count_o
);

    logic a_empty_s;
    logic b_empty_s;
    logic pop_s;

    // A pair exists only when both heads are valid; both sides pop together.
    assign v_o   = ~a_empty_s & ~b_empty_s;
    assign pop_s = v_o & ready_i;

    bsg_and_join_side_fifo #(
        .width_p (width_p),
        .els_p   (els_p)
    ) a_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (a_v_i),
        .data_i    (a_data_i),
        .ready_o   (a_ready_o),
        .pop_i     (pop_s),
        .data_o    (a_o),
        .empty_o   (a_empty_s),
        .count_o   (a_count_o)
    );

    bsg_and_join_side_fifo #(
        .width_p (width_p),
        .els_p   (els_p)
    ) b_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (b_v_i),
        .data_i    (b_data_i),
        .ready_o   (b_ready_o),
        .pop_i     (pop_s),
        .data_o    (b_o),
        .empty_o   (b_empty_s),
        .count_o   (b_count_o)
    );

endmodule

// File: tb/tb_bsg_and_operand_join.sv
// Self-checking bench for bsg_and_operand_join: directed table, streaming,
// backpressure, reset and a randomized els_p=3 run against a queue model.
module tb_bsg_and_operand_join;

    logic        clk;
    logic        rst_n;

    logic        a_v, b_v, rdy;
    logic [63:0] a_d, b_d;
    logic        a_rdy, b_rdy, v;
    logic [63:0] a_o, b_o;
    logic [1:0]  a_cnt, b_cnt;

    logic        a_v3, b_v3, rdy3;
    logic [63:0] a_d3, b_d3;
    logic        a_rdy3, b_rdy3, v3;
    logic [63:0] a_o3, b_o3;
    logic [1:0]  a_cnt3, b_cnt3;

    int n_chk = 0;
    int n_fail = 0;

    bsg_and_operand_join #(.width_p(64), .els_p(2)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .a_v_i(a_v), .a_data_i(a_d), .a_ready_o(a_rdy),
        .b_v_i(b_v), .b_data_i(b_d), .b_ready_o(b_rdy),
        .v_o(v), .a_o(a_o), .b_o(b_o), .ready_i(rdy),
        .a_count_o(a_cnt), .b_count_o(b_cnt)
    );

    bsg_and_operand_join #(.width_p(64), .els_p(3)) dut3 (
        .clk_i(clk), .reset_n_i(rst_n),
        .a_v_i(a_v3), .a_data_i(a_d3), .a_ready_o(a_rdy3),
        .b_v_i(b_v3), .b_data_i(b_d3), .b_ready_o(b_rdy3),
        .v_o(v3), .a_o(a_o3), .b_o(b_o3), .ready_i(rdy3),
        .a_count_o(a_cnt3), .b_count_o(b_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        a_v;
        logic [63:0] a_d;
        logic        b_v;
        logic [63:0] b_d;
        logic        rdy;
        logic [1:0]  ea_cnt;
        logic [1:0]  eb_cnt;
        logic        ev;
        logic        ea_rdy;
        logic        eb_rdy;
        logic        chk_d;
        logic [63:0] ea;
        logic [63:0] eb;
    } vec_t;

    vec_t tbl [8];

    int         qa[$];
    int         qb[$];
    logic [63:0] ma[$];
    logic [63:0] mb[$];

    initial begin
        a_v = 1'b0; b_v = 1'b0; rdy = 1'b0; a_d = 64'd0; b_d = 64'd0;
        a_v3 = 1'b0; b_v3 = 1'b0; rdy3 = 1'b0; a_d3 = 64'd0; b_d3 = 64'd0;
        rst_n = 1'b0;

        // A-only fill, B arrival, full with push/pop, ready with no pair.
        tbl[0] = '{1'b1, 64'h1,  1'b0, 64'h0,  1'b0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'h0};
        tbl[1] = '{1'b1, 64'h2,  1'b0, 64'h0,  1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0};
        tbl[2] = '{1'b1, 64'h3,  1'b1, 64'hF,  1'b0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1, 64'hF};
        tbl[3] = '{1'b1, 64'h4,  1'b0, 64'h0,  1'b1, 2'd1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'h0};
        tbl[4] = '{1'b0, 64'h0,  1'b1, 64'h10, 1'b0, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h2, 64'h10};
        tbl[5] = '{1'b1, 64'h5,  1'b1, 64'h11, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h5, 64'h11};
        tbl[6] = '{1'b0, 64'h0,  1'b0, 64'h0,  1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'h0};
        tbl[7] = '{1'b0, 64'h0,  1'b1, 64'h12, 1'b1, 2'd0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'h0};

        #12;
        chk("rst_v", v, 1'b0);
        chk("rst_a_ready", a_rdy, 1'b1);
        chk("rst_b_ready", b_rdy, 1'b1);
        chk("rst_a_count", a_cnt, 2'd0);
        chk("rst_b_count", b_cnt, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_v", v, 1'b0);
        chk("idle_a_count", a_cnt, 2'd0);

        for (int i = 0; i < 8; i++) begin
            a_v = tbl[i].a_v; a_d = tbl[i].a_d;
            b_v = tbl[i].b_v; b_d = tbl[i].b_d;
            rdy = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_a_count", i), a_cnt, tbl[i].ea_cnt);
            chk($sformatf("tbl%0d_b_count", i), b_cnt, tbl[i].eb_cnt);
            chk($sformatf("tbl%0d_v", i), v, tbl[i].ev);
            chk($sformatf("tbl%0d_a_ready", i), a_rdy, tbl[i].ea_rdy);
            chk($sformatf("tbl%0d_b_ready", i), b_rdy, tbl[i].eb_rdy);
            if (tbl[i].chk_d) begin
                chk($sformatf("tbl%0d_a_o", i), a_o, tbl[i].ea);
                chk($sformatf("tbl%0d_b_o", i), b_o, tbl[i].eb);
            end
        end

        // Mid-stream asynchronous reset with two A entries buffered.
        a_v = 1'b1; b_v = 1'b0; rdy = 1'b0; a_d = 64'hA;
        step();
        a_d = 64'hB;
        step();
        a_v = 1'b0;
        chk("pre_rst_a_count", a_cnt, 2'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_a_count", a_cnt, 2'd0);
        chk("async_rst_b_count", b_cnt, 2'd0);
        chk("async_rst_a_ready", a_rdy, 1'b1);
        chk("async_rst_v", v, 1'b0);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_a_count", a_cnt, 2'd0);
        b_v = 1'b1; b_d = 64'hC;
        a_v = 1'b1; a_d = 64'hD;
        step();
        chk("post_rst_pair0_a", a_o, 64'hD);
        chk("post_rst_pair0_b", b_o, 64'hC);
        a_v = 1'b0; b_v = 1'b0; rdy = 1'b1;
        step();
        chk("post_rst_drain_v", v, 1'b0);

        // Streaming: one pair per cycle, pair i visible the cycle after push i.
        for (int i = 0; i < 100; i++) begin
            a_v = 1'b1; a_d = 64'(i);
            b_v = 1'b1; b_d = 64'(i);
            rdy = 1'b1;
            step();
            chk("stream_v", v, 1'b1);
            chk("stream_a_o", a_o, 64'(i));
            chk("stream_b_o", b_o, 64'(i));
        end
        a_v = 1'b0; b_v = 1'b0;
        step();
        chk("stream_end_v", v, 1'b0);

        // Backpressure: stall at count 2, then drain in order.
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_v = 1'b1; a_d = 64'(200 + i);
            b_v = 1'b1; b_d = 64'(300 + i);
            step();
        end
        chk("bp_a_count", a_cnt, 2'd2);
        chk("bp_b_count", b_cnt, 2'd2);
        chk("bp_a_ready", a_rdy, 1'b0);
        chk("bp_b_ready", b_rdy, 1'b0);
        chk("bp_head_a", a_o, 64'd200);
        chk("bp_head_b", b_o, 64'd300);
        a_v = 1'b0; b_v = 1'b0; rdy = 1'b1;
        step();
        chk("bp_drain1_v", v, 1'b1);
        chk("bp_drain1_a", a_o, 64'd201);
        chk("bp_drain1_b", b_o, 64'd301);
        step();
        chk("bp_drain2_v", v, 1'b0);
        chk("bp_drain2_a_count", a_cnt, 2'd0);
        rdy = 1'b0;

        // Randomized skewed traffic on the els_p=3 instance versus queue model.
        begin
            int   pairs;
            int   cyc;
            bit   a_hs, b_hs, pop, exp_v;
            int   pa, pb;
            pairs = 0;
            cyc   = 0;
            while (pairs < 1000 && cyc < 20000) begin
                exp_v = (ma.size() > 0) && (mb.size() > 0);
                chk("rnd_a_count", a_cnt3, 64'(ma.size()));
                chk("rnd_b_count", b_cnt3, 64'(mb.size()));
                chk("rnd_v", v3, exp_v);
                chk("rnd_a_ready", a_rdy3, ma.size() < 3);
                if (exp_v) begin
                    chk("rnd_pair_a", a_o3, ma[0]);
                    chk("rnd_pair_b", b_o3, mb[0]);
                end
                pa = ((cyc / 150) % 2 == 0) ? 80 : 30;
                pb = 110 - pa;
                a_v3 = ($urandom_range(99) < pa);
                b_v3 = ($urandom_range(99) < pb);
                rdy3 = ($urandom_range(99) < 60);
                a_d3 = {$urandom, $urandom};
                b_d3 = {$urandom, $urandom};
                a_hs = a_v3 && (ma.size() < 3);
                b_hs = b_v3 && (mb.size() < 3);
                pop  = exp_v && rdy3;
                step();
                if (pop) begin
                    void'(ma.pop_front());
                    void'(mb.pop_front());
                    pairs++;
                end
                if (a_hs) ma.push_back(a_d3);
                if (b_hs) mb.push_back(b_d3);
                cyc++;
            end
            n_chk++;
            if (pairs < 1000) begin
                n_fail++;
                $display("FAIL rnd_budget actual=%0d pairs required=1000", pairs);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
